// File: rtl/jtpang_objdma.sv
// Object DMA: copies 2^AW bytes of object VRAM into the idle half of a
// double-buffered sprite table while holding the CPU off the bus.
module jtpang_objdma #(
  parameter int AW     = 9,
  parameter int BUSLAT = 0
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_bank,
  output logic          busy
);

  localparam int            WW        = $clog2(BUSLAT + 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(BUSLAT);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, COPY, FLUSH, REL} state_t;

  state_t        state_q;
  logic          go_q, armed_q, go_edge;
  logic          pending_q, pending_d;
  logic          busrq_q, busy_q, buf_we_q, buf_bank_q;
  logic [AW-1:0] dma_addr_q, dma_addr_d, buf_addr_q;
  logic [WW-1:0] wait_q;

  // armed_q blocks a dma_go that was already high across reset from
  // counting as an edge; it needs to be seen low first.
  always_comb begin
    go_edge    = dma_go & ~go_q & armed_q;
    pending_d  = pending_q;
    if (state_q == IDLE && pending_q) pending_d = 1'b0;
    if (go_edge) pending_d = 1'b1;
    dma_addr_d = dma_addr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      go_q       <= 1'b0;
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_bank_q <= 1'b0;
      dma_addr_q <= '0;
      buf_addr_q <= '0;
      wait_q     <= '0;
    end else begin
      go_q      <= dma_go;
      pending_q <= pending_d;
      buf_we_q  <= 1'b0;
      if (!dma_go) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q <= REQ;
            busrq_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (!busak_n) begin
            state_q <= WAIT;
            wait_q  <= '0;
          end
        end
        WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q    <= COPY;
            dma_addr_q <= '0;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        // Each granted cycle issues one read; its write lands the next cycle,
        // when the VRAM data is valid.
        COPY: begin
          if (!busak_n) begin
            buf_we_q   <= 1'b1;
            buf_addr_q <= dma_addr_q;
            if (dma_addr_q == ADDR_LAST) state_q <= FLUSH;
            else dma_addr_q <= dma_addr_d;
          end
        end
        FLUSH: begin
          state_q    <= REL;
          busrq_q    <= 1'b0;
          buf_bank_q <= ~buf_bank_q;
        end
        REL: begin
          if (busak_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_bank = buf_bank_q;
  assign dma_addr = dma_addr_q;
  assign buf_din  = buf_we_q ? dma_din : 8'h00;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Scoreboard bench for jtpang_objdma: a main instance (AW=9, BUSLAT=0) with a
// CPU bus model, plus a small BUSLAT=3 instance for the wait-latency check.
module tb_jtpang_objdma;

  localparam int AW = 9;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1, dma_go = 1'b0, busak_n = 1'b1;
  logic [7:0]    dma_din = 8'h00;
  logic          busrq, buf_we, buf_bank, busy;
  logic [AW-1:0] dma_addr, buf_addr;
  logic [7:0]    buf_din;

  logic       go3 = 1'b0, busak3_n = 1'b1;
  logic [7:0] din3 = 8'h00;
  logic       busrq3, we3, bank3, busy3;
  logic [3:0] addr3, baddr3;
  logic [7:0] bdin3;

  int testsRun = 0, testsFailed = 0;
  int cyc = 0, addr101Cnt = 0;
  int ackCnt = 0, stallCnt = 0, stallReq = 0, stallSeen = 0;
  int obsRd = 0;

  logic [7:0]    vram [N];
  logic [AW+7:0] expQ [$];
  logic [AW+7:0] obsQ [$];
  int            obsCyc [$];

  jtpang_objdma #(.AW(AW), .BUSLAT(0)) dut (
    .rst(rst), .clk(clk), .dma_go(dma_go), .busak_n(busak_n), .busrq(busrq),
    .dma_addr(dma_addr), .dma_din(dma_din), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_din(buf_din), .buf_bank(buf_bank), .busy(busy)
  );

  jtpang_objdma #(.AW(4), .BUSLAT(3)) dut3 (
    .rst(rst), .clk(clk), .dma_go(go3), .busak_n(busak3_n), .busrq(busrq3),
    .dma_addr(addr3), .dma_din(din3), .buf_we(we3), .buf_addr(baddr3),
    .buf_din(bdin3), .buf_bank(bank3), .busy(busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dma_din <= vram[dma_addr];
  always @(posedge clk) din3 <= {4'h0, addr3} ^ 8'hA5;

  // CPU bus model: grants 3 cycles after busrq, optionally stalls once
  // for 5 cycles right after address 100 has been issued.
  always begin
    @(posedge clk);
    #1;
    if (!busrq) begin
      busak_n = 1'b1;
      ackCnt  = 0;
    end else if (stallCnt > 0) begin
      stallCnt--;
      if (stallCnt == 0) busak_n = 1'b0;
    end else if (stallReq != stallSeen && !busak_n && dma_addr == AW'(101)) begin
      stallSeen = stallReq;
      stallCnt  = 5;
      busak_n   = 1'b1;
    end else if (busak_n) begin
      ackCnt++;
      if (ackCnt >= 3) busak_n = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (buf_we) begin
      obsQ.push_back({buf_addr, buf_din});
      obsCyc.push_back(cyc);
    end
    if (busrq && dma_addr == AW'(101)) addr101Cnt++;
  end

  task automatic pushExpected;
    for (int i = 0; i < N; i++) expQ.push_back({AW'(i), vram[i]});
  endtask

  task automatic scoreWrites(output int firstBad, output int nObs);
    logic [AW+7:0] e, o;
    int idx = 0;
    firstBad = -1;
    nObs = obsQ.size() - obsRd;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (obsRd < obsQ.size()) begin
        o = obsQ[obsRd];
        obsRd++;
      end else begin
        o = 'x;
      end
      if (o !== e && firstBad < 0) firstBad = idx;
      idx++;
    end
    if (obsRd < obsQ.size() && firstBad < 0) firstBad = idx;
    obsRd = obsQ.size();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dma_go = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (busrq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busrq: got %b want 0", busrq); end
    testsRun++;
    if ({buf_we, busy, buf_bank} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags: we/busy/bank got %b want 000", {buf_we, busy, buf_bank});
    end
    testsRun++;
    if ({dma_addr, buf_addr, buf_din} !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_buses: dma_addr %0d buf_addr %0d buf_din %0d want all 0", dma_addr, buf_addr, buf_din);
    end
    testsRun++;
    if ({busrq3, we3, bank3, busy3} !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL reset_dut3: got %b want 0000", {busrq3, we3, bank3, busy3});
    end
    @(negedge clk);
    rst = 1'b0;
    obsRd = obsQ.size();
    expQ.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int n, bad, nObs;
    logic startBank;
    logic [AW+7:0] last;
    startBank = buf_bank;
    pushExpected();
    dma_go = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!busrq && n < 10);
    testsRun++;
    if (n !== 2) begin testsFailed++; $display("[TB] FAIL go_to_busrq: got %0d cycles want 2", n); end
    dma_go = 1'b0;
    n = 0;
    while (busrq && n < 3000) begin @(negedge clk); n++; end
    testsRun++;
    if (busrq !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_timeout: busrq still %b want 0", busrq); end
    last = (obsQ.size() > obsRd) ? obsQ[obsQ.size()-1] : '0;
    testsRun++;
    if (obsQ.size() - obsRd != N || last[AW+7:8] !== AW'(N-1)) begin
      testsFailed++; $display("[TB] FAIL busrq_fall: %0d writes, last addr %0d, want %0d writes ending at %0d", obsQ.size() - obsRd, last[AW+7:8], N, N-1);
    end
    testsRun++;
    if (buf_bank !== ~startBank) begin testsFailed++; $display("[TB] FAIL basic_bank: got %b want %b", buf_bank, ~startBank); end
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    scoreWrites(bad, nObs);
    testsRun++;
    if (bad >= 0 || nObs != N) begin
      testsFailed++; $display("[TB] FAIL basic_writes: got %0d writes first bad %0d, want %0d in-order VRAM writes", nObs, bad, N);
    end
  endtask

  task automatic test_stall;
    int n, bad, nObs, base, c100, cyc100, cyc101;
    logic startBank;
    logic [AW+7:0] w;
    startBank = buf_bank;
    base = addr101Cnt;
    stallReq++;
    pushExpected();
    dma_go = 1'b1;
    repeat (2) @(negedge clk);
    dma_go = 1'b0;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_timeout: busy %b want 0", busy); end
    testsRun++;
    if (addr101Cnt - base != 6) begin
      testsFailed++; $display("[TB] FAIL stall_hold: dma_addr=101 for %0d cycles want 6", addr101Cnt - base);
    end
    c100 = 0; cyc100 = -1; cyc101 = -1;
    for (int i = obsRd; i < obsQ.size(); i++) begin
      w = obsQ[i];
      if (w[AW+7:8] == AW'(100)) begin c100++; cyc100 = obsCyc[i]; end
      if (w[AW+7:8] == AW'(101) && cyc101 < 0) cyc101 = obsCyc[i];
    end
    testsRun++;
    if (c100 != 1 || cyc101 - cyc100 != 6) begin
      testsFailed++; $display("[TB] FAIL stall_gap: addr100 written %0d times, gap to 101 %0d cycles, want 1 and 6", c100, cyc101 - cyc100);
    end
    scoreWrites(bad, nObs);
    testsRun++;
    if (bad >= 0 || nObs != N) begin
      testsFailed++; $display("[TB] FAIL stall_writes: got %0d writes first bad %0d, want %0d in-order VRAM writes", nObs, bad, N);
    end
    testsRun++;
    if (buf_bank !== ~startBank) begin testsFailed++; $display("[TB] FAIL stall_bank: got %b want %b", buf_bank, ~startBank); end
  endtask

  task automatic test_back_to_back;
    int rises = 0, lowGap = 0, quiet = 0, bad, nObs;
    logic prev = 1'b0;
    logic startBank;
    startBank = buf_bank;
    pushExpected();
    pushExpected();
    for (int i = 0; i < 4000 && quiet < 30; i++) begin
      dma_go = (i < 2) || (i >= 50 && i < 52) || (i >= 54 && i < 56);
      @(negedge clk);
      if (busrq && !prev) rises++;
      if (rises == 1 && !busrq) lowGap++;
      prev = busrq;
      if (rises >= 2 && !busy) quiet++;
    end
    dma_go = 1'b0;
    testsRun++;
    if (rises != 2) begin testsFailed++; $display("[TB] FAIL b2b_count: %0d transfers want 2", rises); end
    testsRun++;
    if (lowGap < 1) begin testsFailed++; $display("[TB] FAIL b2b_gap: busrq low %0d cycles between transfers want >=1", lowGap); end
    testsRun++;
    if (buf_bank !== startBank) begin testsFailed++; $display("[TB] FAIL b2b_bank: got %b want %b", buf_bank, startBank); end
    scoreWrites(bad, nObs);
    testsRun++;
    if (bad >= 0 || nObs != 2 * N) begin
      testsFailed++; $display("[TB] FAIL b2b_writes: got %0d writes first bad %0d, want %0d in-order VRAM writes", nObs, bad, 2 * N);
    end
  endtask

  task automatic test_reset_mid;
    int n, highs, bad, nObs;
    logic bankBefore;
    dma_go = 1'b1;
    repeat (2) @(negedge clk);
    dma_go = 1'b0;
    n = 0;
    while (dma_addr != AW'(200) && n < 1000) begin @(negedge clk); n++; end
    bankBefore = buf_bank;
    dma_go = 1'b1;
    rst = 1'b1;
    #1;
    testsRun++;
    if (busrq !== 1'b0 || busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rstmid_busrq: busrq %b busy %b want 0 0", busrq, busy);
    end
    testsRun++;
    if (buf_bank !== bankBefore) begin testsFailed++; $display("[TB] FAIL rstmid_bank: got %b want %b", buf_bank, bankBefore); end
    @(negedge clk);
    rst = 1'b0;
    obsRd = obsQ.size();
    expQ.delete();
    highs = 0;
    repeat (20) begin @(negedge clk); if (busrq) highs++; end
    testsRun++;
    if (highs != 0) begin testsFailed++; $display("[TB] FAIL rstmid_held_go: busrq high %0d cycles want 0", highs); end
    dma_go = 1'b0;
    repeat (2) @(negedge clk);
    pushExpected();
    dma_go = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!busrq && n < 10);
    testsRun++;
    if (n !== 2) begin testsFailed++; $display("[TB] FAIL rstmid_retrigger: got %0d cycles want 2", n); end
    dma_go = 1'b0;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    scoreWrites(bad, nObs);
    testsRun++;
    if (bad >= 0 || nObs != N) begin
      testsFailed++; $display("[TB] FAIL rstmid_writes: got %0d writes first bad %0d, want %0d in-order VRAM writes", nObs, bad, N);
    end
    testsRun++;
    if (buf_bank !== ~bankBefore) begin testsFailed++; $display("[TB] FAIL rstmid_bank_after: got %b want %b", buf_bank, ~bankBefore); end
  endtask

  task automatic test_buslat;
    logic [11:0] exp3 [$];
    logic [11:0] e;
    int n, writes = 0, bad = -1;
    for (int i = 0; i < 16; i++) exp3.push_back({4'(i), 8'(i) ^ 8'hA5});
    go3 = 1'b1;
    n = 0;
    while (!busrq3 && n < 10) begin @(negedge clk); n++; end
    go3 = 1'b0;
    busak3_n = 1'b0;
    @(negedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!we3 && n < 20);
    testsRun++;
    if (n !== 5) begin testsFailed++; $display("[TB] FAIL buslat_first_we: got %0d cycles want 5", n); end
    n = 0;
    while (busrq3 && n < 100) begin
      if (we3) begin
        e = (exp3.size() > 0) ? exp3.pop_front() : 'x;
        if ({baddr3, bdin3} !== e && bad < 0) bad = writes;
        writes++;
      end
      @(negedge clk);
      n++;
    end
    busak3_n = 1'b1;
    testsRun++;
    if (writes != 16 || bad >= 0) begin
      testsFailed++; $display("[TB] FAIL buslat_writes: got %0d writes first bad %0d, want 16 in order", writes, bad);
    end
    n = 0;
    while (busy3 && n < 20) begin @(negedge clk); n++; end
    testsRun++;
    if ({busy3, bank3} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL buslat_end: busy/bank got %b want 01", {busy3, bank3});
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) vram[i] = 8'($urandom_range(1, 255));
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_buslat();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
